// File: rtl/flash_ctrl_pkg.sv
// Shared flash controller types.
//   data_region_attr_t  : per-region attribute consumed by the data-region
//                         selector (currently only the phase field).
//   region_cfg_state_e  : state of the region-configuration commit FSM.
package flash_ctrl_pkg;

  typedef struct packed {
    logic phase;
  } data_region_attr_t;

  typedef enum logic {
    StIdle   = 1'b0,
    StCommit = 1'b1
  } region_cfg_state_e;

endpackage

// File: rtl/flash_mp_region_cfg.sv
// Flash memory-protection data-region configuration.
// Software writes land in a shadow bank; a commit sweeps the shadow bank into
// the active bank one region per cycle; the active bank is presented to the
// data-region selector. A sticky lock freezes the configuration until reset.
//
// Ports:
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   wr_req_i/wr_idx_i/wr_attr_i: shadow write request (held until wr_ack_o)
//   wr_ack_o                   : one-cycle write completion pulse
//   err_o                      : one-cycle error pulse (rejected write/commit)
//   commit_i                   : single-cycle commit request
//   lock_i                     : lock request
//   busy_o                     : commit sweep in progress
//   locked_o                   : configuration frozen
//   rd_idx_i/rd_attr_o         : combinational shadow read-back
//   region_attrs_o             : registered active attributes
module flash_mp_region_cfg
  import flash_ctrl_pkg::*;
#(
  parameter int NumRegions = 8,
  parameter int IdxW       = $clog2(NumRegions)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_req_i,
  input  logic [IdxW-1:0]   wr_idx_i,
  input  data_region_attr_t wr_attr_i,
  output logic              wr_ack_o,
  output logic              err_o,
  input  logic              commit_i,
  input  logic              lock_i,
  output logic              busy_o,
  output logic              locked_o,
  input  logic [IdxW-1:0]   rd_idx_i,
  output data_region_attr_t rd_attr_o,
  output data_region_attr_t region_attrs_o [NumRegions]
);

  region_cfg_state_e state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic              lock_pend_q, lock_pend_d;
  data_region_attr_t shadow_q [NumRegions];
  data_region_attr_t shadow_d [NumRegions];
  data_region_attr_t active_q [NumRegions];
  data_region_attr_t active_d [NumRegions];

  logic idle;
  logic wr_accept;
  logic wr_ok;
  logic commit_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    lock_pend_d = lock_pend_q;
    locked_d    = locked_q;

    idle = (state_q == StIdle);
    // A request still high in its own ack cycle is the tail of the previous
    // handshake, not a new request.
    wr_accept = idle && wr_req_i && !wr_ack_q;
    wr_ok     = wr_accept && !locked_q && (int'(wr_idx_i) < NumRegions);
    commit_ok = idle && commit_i && !locked_q;

    wr_ack_d = wr_accept;
    err_d    = (wr_accept && !wr_ok) || (idle && commit_i && locked_q);

    // The write lands before the sweep starts reading, so a same-cycle
    // write and commit commits the new data.
    if (wr_ok) begin
      shadow_d[wr_idx_i] = wr_attr_i;
    end

    case (state_q)
      StIdle: begin
        if (commit_ok) begin
          state_d = StCommit;
          cnt_d   = '0;
        end
        if (lock_i || lock_pend_q) begin
          locked_d    = 1'b1;
          lock_pend_d = 1'b0;
        end
      end
      StCommit: begin
        active_d[cnt_q] = shadow_q[cnt_q];
        // Lock is deferred so the sweep always completes atomically.
        if (lock_i) begin
          lock_pend_d = 1'b1;
        end
        if (cnt_q == IdxW'(NumRegions - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      lock_pend_q <= 1'b0;
      for (int i = 0; i < NumRegions; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ack_q    <= wr_ack_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      lock_pend_q <= lock_pend_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    rd_attr_o = '0;
    if (int'(rd_idx_i) < NumRegions) begin
      rd_attr_o = shadow_q[rd_idx_i];
    end
  end

  assign wr_ack_o       = wr_ack_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q == StCommit);
  assign locked_o       = locked_q;
  assign region_attrs_o = active_q;

endmodule

// File: tb/tb_flash_mp_region_cfg.sv
// Bench for flash_mp_region_cfg: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a timing-level model.
module tb_flash_mp_region_cfg;
  import flash_ctrl_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-region instance
  logic              wr_req = 1'b0;
  logic [2:0]        wr_idx = '0;
  data_region_attr_t wr_attr = '0;
  logic              commit = 1'b0;
  logic              lock = 1'b0;
  logic [2:0]        rd_idx = '0;
  logic              wr_ack, err, busy, locked;
  data_region_attr_t rd_attr;
  data_region_attr_t r8 [N];

  // 6-region instance, used for out-of-range indices
  logic              w6_req = 1'b0;
  logic [2:0]        w6_idx = '0;
  data_region_attr_t w6_attr = '0;
  logic              c6 = 1'b0;
  logic              l6 = 1'b0;
  logic [2:0]        rd6_idx = '0;
  logic              ack6, err6, busy6, locked6;
  data_region_attr_t rd6_attr;
  data_region_attr_t r6 [6];

  flash_mp_region_cfg #(.NumRegions(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_attr_i(wr_attr),
    .wr_ack_o(wr_ack), .err_o(err), .commit_i(commit), .lock_i(lock),
    .busy_o(busy), .locked_o(locked), .rd_idx_i(rd_idx), .rd_attr_o(rd_attr),
    .region_attrs_o(r8)
  );

  flash_mp_region_cfg #(.NumRegions(6)) dut6 (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_i(w6_req), .wr_idx_i(w6_idx), .wr_attr_i(w6_attr),
    .wr_ack_o(ack6), .err_o(err6), .commit_i(c6), .lock_i(l6),
    .busy_o(busy6), .locked_o(locked6), .rd_idx_i(rd6_idx), .rd_attr_o(rd6_attr),
    .region_attrs_o(r6)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (8-region instance) ----------------
  // Tracks time of the last accepted commit; busy and per-region visibility
  // are derived from that time by the documented latencies.
  int  cyc = 0;
  bit  started = 0;
  bit  have_sweep = 0;
  int  st = 0;
  bit  m_shadow [N];
  bit  snap [N];
  bit  base [N];
  bit  m_ack = 0, m_err = 0, m_locked = 0, m_pend = 0;

  function automatic bit busy_at(int c);
    return have_sweep && (c >= st + 1) && (c <= st + N);
  endfunction

  always @(posedge clk) begin
    bit idle, accept, inr, n_err, n_locked;
    if (!rst_n) begin
      started = 1;
      have_sweep = 0;
      m_ack = 0; m_err = 0; m_locked = 0; m_pend = 0;
      for (int k = 0; k < N; k++) begin
        m_shadow[k] = 0; snap[k] = 0; base[k] = 0;
      end
    end else begin
      idle   = !busy_at(cyc);
      accept = idle && wr_req && !m_ack;
      inr    = (int'(wr_idx) < N);
      n_err  = (accept && (m_locked || !inr)) || (idle && commit && m_locked);
      if (accept && !m_locked && inr) m_shadow[wr_idx] = wr_attr.phase;
      if (idle && commit && !m_locked) begin
        if (have_sweep) for (int k = 0; k < N; k++) base[k] = snap[k];
        for (int k = 0; k < N; k++) snap[k] = m_shadow[k];
        st = cyc;
        have_sweep = 1;
      end
      n_locked = m_locked;
      if (idle && (lock || m_pend)) begin
        n_locked = 1; m_pend = 0;
      end else if (!idle && lock) begin
        m_pend = 1;
      end
      m_ack = accept; m_err = n_err; m_locked = n_locked;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(busy_at(cyc)));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("rd_attr", 32'(rd_attr.phase), 32'(m_shadow[rd_idx]));
      for (int k = 0; k < N; k++)
        chk($sformatf("region%0d", k), 32'(r8[k].phase),
            32'((have_sweep && cyc >= st + 2 + k) ? snap[k] : base[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; commit = 1'b0; lock = 1'b0; w6_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    do_reset();
    chk("rst_ack", 32'(wr_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_region3", 32'(r8[3].phase), 0);

    // write region 3
    wr_req = 1'b1; wr_idx = 3'd3; wr_attr.phase = 1'b1;
    step();
    chk("w3_ack", 32'(wr_ack), 1);
    chk("w3_err", 32'(err), 0);
    wr_req = 1'b0; rd_idx = 3'd3; #1;
    chk("w3_rd", 32'(rd_attr.phase), 1);
    chk("w3_active", 32'(r8[3].phase), 0);

    // commit: busy 8 cycles, region 3 visible at commit+5
    commit = 1'b1; step(); commit = 1'b0;
    bc = 0;
    for (int i = 1; i <= 12; i++) begin
      if (busy) bc++;
      if (i == 4) chk("c_r3_early", 32'(r8[3].phase), 0);
      if (i == 5) chk("c_r3", 32'(r8[3].phase), 1);
      step();
    end
    chk("c_busy_cycles", 32'(bc), 8);
    chk("c_r0", 32'(r8[0].phase), 0);
    chk("c_r7", 32'(r8[7].phase), 0);

    // write idx 2 with commit in the same cycle, then a write during the sweep
    wr_req = 1'b1; wr_idx = 3'd2; wr_attr.phase = 1'b1; commit = 1'b1;
    step();
    commit = 1'b0;
    chk("wc_ack", 32'(wr_ack), 1);
    wr_idx = 3'd5; wr_attr.phase = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) chk("wc_r2_early", 32'(r8[2].phase), 0);
      if (i == 4) chk("wc_r2", 32'(r8[2].phase), 1);
      if (i >= 2 && i <= 9) chk("stall_noack", 32'(wr_ack), 0);
      if (i == 10) begin
        chk("stall_ack", 32'(wr_ack), 1);
        wr_req = 1'b0;
      end
      if (i != 1) step();
      else step();
    end

    // lock mid-sweep
    commit = 1'b1; step(); commit = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      lock = (i == 3);
      if (i == 8) chk("lk_busy_last", 32'(busy), 1);
      if (i == 9) begin
        chk("lk_busy_fall", 32'(busy), 0);
        chk("lk_not_yet", 32'(locked), 0);
      end
      if (i == 10) chk("lk_locked", 32'(locked), 1);
      step();
    end
    wr_req = 1'b1; wr_idx = 3'd5; wr_attr.phase = 1'b0;
    step();
    chk("lk_w_ack", 32'(wr_ack), 1);
    chk("lk_w_err", 32'(err), 1);
    wr_req = 1'b0; rd_idx = 3'd5; #1;
    chk("lk_shadow_kept", 32'(rd_attr.phase), 1);
    commit = 1'b1; step(); commit = 1'b0;
    chk("lk_c_err", 32'(err), 1);
    chk("lk_c_busy", 32'(busy), 0);
    step();
    chk("lk_c_busy2", 32'(busy), 0);
    chk("lk_c_err2", 32'(err), 0);

    // out-of-range write on the 6-region instance
    w6_req = 1'b1; w6_idx = 3'd7; w6_attr.phase = 1'b1;
    step();
    chk("oor_ack", 32'(ack6), 1);
    chk("oor_err", 32'(err6), 1);
    w6_req = 1'b0; rd6_idx = 3'd7; #1;
    chk("oor_rd", 32'(rd6_attr.phase), 0);
    step();
    w6_req = 1'b1; w6_idx = 3'd5; w6_attr.phase = 1'b1;
    step();
    chk("inr6_ack", 32'(ack6), 1);
    chk("inr6_err", 32'(err6), 0);
    w6_req = 1'b0; rd6_idx = 3'd5; #1;
    chk("inr6_rd", 32'(rd6_attr.phase), 1);

    // reset clears lock; then reset in the middle of a sweep
    do_reset();
    chk("rr_locked", 32'(locked), 0);
    wr_req = 1'b1; wr_idx = 3'd0; wr_attr.phase = 1'b1;
    step(); wr_req = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    step(); step(); step();
    chk("mr_r0_before", 32'(r8[0].phase), 1);
    chk("mr_busy_before", 32'(busy), 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mr_r0", 32'(r8[0].phase), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_locked", 32'(locked), 0);
    rd_idx = 3'd0; #1;
    chk("mr_rd", 32'(rd_attr.phase), 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if (wr_req && wr_ack) begin
          wr_req = 1'b0;
        end else if (!wr_req && $urandom_range(0, 2) == 0) begin
          wr_req = 1'b1;
          wr_idx = 3'($urandom_range(0, 7));
          wr_attr.phase = 1'($urandom_range(0, 1));
        end
        commit = ($urandom_range(0, 11) == 0);
        lock   = ($urandom_range(0, 399) == 0);
        rd_idx = 3'($urandom_range(0, 7));
        step();
      end
    end
    wr_req = 1'b0; commit = 1'b0; lock = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
